dmem_copy_engine: RTL and testbench

Bus-initiator block that drives the data-memory/IO bus (address, write data, read/write strobes) to copy a block of 16-bit words from one word-aligned region to another. It sits beside the MIPS datapath as a second master of the `DMemory_IO` port, which remains the responder. External arbitration grants the bus to the engine while `busy` is high. Software or a controller loads source, destination and count, pulses `start`, and waits for `done`.

---
 rtl/dmem_copy_engine.sv | 180 ++++++++++++++++++
 tb/tb_dmem_copy_engine.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_copy_engine.sv
// dmem_copy_engine
// Second bus master beside the MIPS datapath that copies a block of 16-bit
// words from one word-aligned byte region to another over the DMemory_IO bus.
// External arbitration hands the bus to this engine while busy is high.
//
// Ports:
//   clock       rising-edge clock
//   reset       synchronous active-high reset
//   start       job request, only looked at while idle
//   src_addr    source byte address (bit 0 dropped at capture)
//   dst_addr    destination byte address (bit 0 dropped at capture)
//   word_count  number of 16-bit words to move
//   fill_mode   (DMA_FILL_EN only) write fill_value instead of copying
//   fill_value  (DMA_FILL_EN only) word written in fill mode
//   bus_rdata   responder read data, valid in the same cycle as bus_read
//   bus_addr    bus byte address
//   bus_wdata   bus write data
//   bus_read    read strobe
//   bus_write   write strobe, committed by the responder on the rising edge
//   busy        high whenever a job is in flight (any state but IDLE)
//   done        one-cycle completion pulse
//
// Build option: define DMA_FILL_EN to add the memory-fill mode.
module dmem_copy_engine #(
    parameter int ADDR_STEP = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [15:0]      src_addr,
    input  logic [15:0]      dst_addr,
    input  logic [CNT_W-1:0] word_count,
`ifdef DMA_FILL_EN
    input  logic             fill_mode,
    input  logic [15:0]      fill_value,
`endif
    input  logic [15:0]      bus_rdata,
    output logic [15:0]      bus_addr,
    output logic [15:0]      bus_wdata,
    output logic             bus_read,
    output logic             bus_write,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [15:0]      STEP = 16'(ADDR_STEP);
    localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [15:0]      src_ptr;
    logic [15:0]      dst_ptr;
    logic [CNT_W-1:0] remaining;

`ifdef DMA_FILL_EN
    logic        fill_reg;
    logic [15:0] fill_val_reg;
    logic        start_fill;
    logic [15:0] start_fill_val;
    assign start_fill     = fill_mode;
    assign start_fill_val = fill_value;
`else
    localparam logic        fill_reg       = 1'b0;
    localparam logic [15:0] fill_val_reg   = 16'h0000;
    localparam logic        start_fill     = 1'b0;
    localparam logic [15:0] start_fill_val = 16'h0000;
`endif

    // All outputs are registered and loaded together with the next state, so
    // they always reflect the state the machine is in. The bus_wdata register
    // doubles as the data holding register: the word read in READ is loaded
    // straight into it on the READ->WRITE edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            src_ptr   <= 16'h0000;
            dst_ptr   <= 16'h0000;
            remaining <= '0;
            bus_addr  <= 16'h0000;
            bus_wdata <= 16'h0000;
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef DMA_FILL_EN
            fill_reg     <= 1'b0;
            fill_val_reg <= 16'h0000;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr   <= {src_addr[15:1], 1'b0};
                        dst_ptr   <= {dst_addr[15:1], 1'b0};
                        remaining <= word_count;
                        busy      <= 1'b1;
`ifdef DMA_FILL_EN
                        fill_reg     <= fill_mode;
                        fill_val_reg <= fill_value;
`endif
                        if (word_count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (start_fill) begin
                            // Fill jobs have no read phase at all.
                            state     <= WRITE;
                            bus_write <= 1'b1;
                            bus_addr  <= {dst_addr[15:1], 1'b0};
                            bus_wdata <= start_fill_val;
                        end else begin
                            state    <= READ;
                            bus_read <= 1'b1;
                            bus_addr <= {src_addr[15:1], 1'b0};
                        end
                    end
                end

                READ: begin
                    state     <= WRITE;
                    bus_read  <= 1'b0;
                    bus_write <= 1'b1;
                    bus_addr  <= dst_ptr;
                    bus_wdata <= bus_rdata;
                end

                WRITE: begin
                    dst_ptr   <= dst_ptr + STEP;
                    remaining <= remaining - ONE;
                    if (!fill_reg) begin
                        src_ptr <= src_ptr + STEP;
                    end
                    // remaining still holds the count including the word
                    // being written now, so 1 means this is the last one.
                    if (remaining != ONE) begin
                        if (fill_reg) begin
                            bus_addr  <= dst_ptr + STEP;
                            bus_wdata <= fill_val_reg;
                        end else begin
                            state     <= READ;
                            bus_write <= 1'b0;
                            bus_read  <= 1'b1;
                            bus_addr  <= src_ptr + STEP;
                            bus_wdata <= 16'h0000;
                        end
                    end else begin
                        state     <= DONE;
                        bus_write <= 1'b0;
                        bus_addr  <= 16'h0000;
                        bus_wdata <= 16'h0000;
                        done      <= 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state     <= IDLE;
                    bus_read  <= 1'b0;
                    bus_write <= 1'b0;
                    bus_addr  <= 16'h0000;
                    bus_wdata <= 16'h0000;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_copy_engine.sv
// tb_dmem_copy_engine
// Scoreboard bench for dmem_copy_engine. A small byte-addressed memory acts as
// the bus responder (addresses below 0x1000 are RAM, everything else reads 0
// and ignores writes). Each job is first played through a reference copy of
// that memory to build the expected list of bus transactions and the expected
// done cycle; a monitor on the falling edge consumes that list.
`timescale 1ns/1ps
module tb_dmem_copy_engine;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] src_addr = 16'h0;
    logic [15:0] dst_addr = 16'h0;
    logic [7:0]  word_count = 8'h0;
    logic [15:0] bus_rdata;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_read;
    logic        bus_write;
    logic        busy;
    logic        done;
`ifdef DMA_FILL_EN
    logic        fill_mode = 1'b0;
    logic [15:0] fill_value = 16'h0;
`endif

    dmem_copy_engine #(.ADDR_STEP(2), .CNT_W(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .word_count (word_count),
`ifdef DMA_FILL_EN
        .fill_mode  (fill_mode),
        .fill_value (fill_value),
`endif
        .bus_rdata  (bus_rdata),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_read   (bus_read),
        .bus_write  (bus_write),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          isWrite;
        logic [15:0] addr;
        logic [15:0] data;
    } txn_t;

    txn_t        expQ[$];
    int          doneQ[$];
    logic [15:0] dutMem[2048];
    logic [15:0] refMem[2048];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          startCyc = 0;
    int          strobeCount = 0;
    int          doneCount = 0;
    bit          doneSeen = 1'b0;

    // Responder: combinational read, write committed on the rising edge.
    assign bus_rdata = (bus_addr < 16'h1000) ? dutMem[bus_addr[11:1]] : 16'h0000;

    always @(posedge clock) begin
        if (bus_write && bus_addr < 16'h1000) dutMem[bus_addr[11:1]] <= bus_wdata;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flagFail(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: got event expected none", name);
    endtask

    function automatic logic [15:0] refRead(input logic [15:0] a);
        return (a < 16'h1000) ? refMem[a[11:1]] : 16'h0000;
    endfunction

    // Monitor: every strobe cycle must match the head of the expected queue,
    // every done pulse must land on the expected cycle of its job.
    always @(negedge clock) begin
        if (bus_read || bus_write) begin
            strobeCount++;
            check("strobe_exclusive", 64'(bus_read & bus_write), 64'd0);
            if (expQ.size() == 0) begin
                flagFail("unexpected_strobe");
            end else begin
                txn_t t;
                t = expQ.pop_front();
                check("bus_txn", {bus_write, bus_addr, (bus_write ? bus_wdata : 16'h0000)},
                      {t.isWrite, t.addr, t.data});
            end
        end
        if (done) begin
            doneCount++;
            doneSeen = 1'b1;
            if (doneQ.size() == 0) begin
                flagFail("unexpected_done");
            end else begin
                int e;
                e = doneQ.pop_front();
                check("done_cycle", 64'(cyc - startCyc + 1), 64'(e));
            end
        end
    end

    // Plays the job through the reference memory, queues the expectations,
    // then pulses start. cut >= 0 models a job reset after 'cut' words.
    task automatic applyStimulus(input logic [15:0] s, input logic [15:0] d, input logic [7:0] n,
                                 input bit fill, input logic [15:0] fv, input int cut);
        logic [15:0] sp;
        logic [15:0] dp;
        logic [15:0] w;
        int          words;
        txn_t        t;
        sp = {s[15:1], 1'b0};
        dp = {d[15:1], 1'b0};
        words = (cut >= 0) ? cut : int'(n);
        for (int i = 0; i < words; i++) begin
            if (!fill) begin
                w = refRead(sp);
                t.isWrite = 1'b0; t.addr = sp; t.data = 16'h0000;
                expQ.push_back(t);
            end else begin
                w = fv;
            end
            t.isWrite = 1'b1; t.addr = dp; t.data = w;
            expQ.push_back(t);
            if (dp < 16'h1000) refMem[dp[11:1]] = w;
            sp = sp + 16'd2;
            dp = dp + 16'd2;
        end
        if (cut < 0) doneQ.push_back((n == 0) ? 1 : (fill ? int'(n) + 1 : 2 * int'(n) + 1));
        @(negedge clock);
        src_addr = s;
        dst_addr = d;
        word_count = n;
`ifdef DMA_FILL_EN
        fill_mode = fill;
        fill_value = fv;
`endif
        start = 1'b1;
        @(posedge clock);
        #1;
        startCyc = cyc;
        doneSeen = 1'b0;
        start = 1'b0;
    endtask

    task automatic waitJob(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            #1;
            if (doneSeen) break;
        end
        check("done_timeout", 64'(doneSeen), 64'd1);
    endtask

    task automatic checkOutput(input string name);
        check(name, {busy, done, bus_read, bus_write, bus_addr, bus_wdata}, 64'd0);
    endtask

    task automatic checkMem(input string name);
        int diff;
        diff = 0;
        for (int i = 0; i < 2048; i++) if (dutMem[i] !== refMem[i]) diff++;
        check(name, 64'(diff), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        int sc;
        int dc;
        logic [15:0] s;
        logic [15:0] d;
        logic [7:0]  n;
        bit          f;

        for (int i = 0; i < 2048; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            dutMem[i] = v;
            refMem[i] = v;
        end
        dutMem[8] = 16'hAAAA;  refMem[8] = 16'hAAAA;
        dutMem[9] = 16'h1234;  refMem[9] = 16'h1234;
        dutMem[10] = 16'hFFFF; refMem[10] = 16'hFFFF;

        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_state");
        reset = 1'b0;

        // Basic copy with odd destination
        applyStimulus(16'h0010, 16'h0041, 8'd3, 1'b0, 16'h0, -1);
        waitJob(20);
        check("copy_word0", 64'(dutMem[16'h20]), 64'hAAAA);
        check("copy_word2", 64'(dutMem[16'h22]), 64'hFFFF);
        checkMem("mem_after_copy");

        // Zero-length job
        sc = strobeCount;
        applyStimulus(16'h0100, 16'h0200, 8'd0, 1'b0, 16'h0, -1);
        @(negedge clock);
        check("zero_busy_c1", 64'(busy), 64'd1);
        @(negedge clock);
        check("zero_busy_c2", 64'(busy), 64'd0);
        check("zero_no_strobe", 64'(strobeCount - sc), 64'd0);
        check("zero_done_seen", 64'(doneSeen), 64'd1);

        // Start re-pulsed in cycle 3 must be ignored
        sc = strobeCount;
        dc = doneCount;
        applyStimulus(16'h0200, 16'h0400, 8'd4, 1'b0, 16'h0, -1);
        @(posedge clock);
        @(posedge clock);
        #1;
        src_addr = 16'h0600;
        word_count = 8'd1;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        waitJob(20);
        repeat (3) @(negedge clock);
        check("restart_strobes", 64'(strobeCount - sc), 64'd8);
        check("restart_dones", 64'(doneCount - dc), 64'd1);
        checkMem("mem_after_restart");

        // Pointer wrap through unmapped space
        applyStimulus(16'hFFFE, 16'h0080, 8'd2, 1'b0, 16'h0, -1);
        waitJob(20);
        check("wrap_word0", 64'(dutMem[16'h40]), 64'h0000);
        checkMem("mem_after_wrap");

        // Reset during the WRITE cycle of word 2 of 5
        dc = doneCount;
        applyStimulus(16'h0300, 16'h0500, 8'd5, 1'b0, 16'h0, 2);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("reset_midjob");
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check("reset_no_done", 64'(doneCount - dc), 64'd0);
        check("reset_queue_empty", 64'(expQ.size()), 64'd0);
        checkMem("mem_after_reset");

`ifdef DMA_FILL_EN
        applyStimulus(16'h0000, 16'h0020, 8'd4, 1'b1, 16'h5A5A, -1);
        waitJob(20);
        check("fill_word3", 64'(dutMem[16'h13]), 64'h5A5A);
        checkMem("mem_after_fill");
`endif

        // Randomized back-to-back jobs, overlapping regions allowed
        for (int j = 0; j < 25; j++) begin
            s = 16'($urandom_range(0, 16'h0FFF));
            d = ($urandom_range(0, 3) == 0) ? (s + 16'($urandom_range(0, 8))) : 16'($urandom_range(0, 16'h0FFF));
            if ($urandom_range(0, 7) == 0) s = 16'hFFF0 + 16'($urandom_range(0, 15));
            n = 8'($urandom_range(0, 8));
`ifdef DMA_FILL_EN
            f = 1'($urandom_range(0, 1));
`else
            f = 1'b0;
`endif
            applyStimulus(s, d, n, f, 16'($urandom), -1);
            waitJob(2 * int'(n) + 10);
        end
        repeat (3) @(negedge clock);
        checkMem("mem_after_random");
        check("final_txn_queue", 64'(expQ.size()), 64'd0);
        check("final_done_queue", 64'(doneQ.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
